// File: rtl/dec_bcd_accumulator_if.sv
// Keypad-side bundle for dec_bcd_accumulator: one-hot digit strobes in, packed BCD and pulses out.
// master drives the key/command strobes; slave is the accumulator.
interface dec_bcd_accumulator_if #(
  parameter int DIGITS = 4
);
  localparam int CW = $clog2(DIGITS + 1);

  logic [9:0]          inn;
  logic                key_valid;
  logic                bksp;
  logic                clear;
  logic [4*DIGITS-1:0] bcd;
  logic [CW-1:0]       count;
  logic                full;
  logic                accept;
  logic                err;
  logic                ovf;

  // Strobes are single-cycle commands sampled on the rising clk edge; there is no ready back-pressure.
  // Rejected commands are reported one cycle later on err/ovf instead of being held off.
  modport master (
    output inn, key_valid, bksp, clear,
    input  bcd, count, full, accept, err, ovf
  );

  modport slave (
    input  inn, key_valid, bksp, clear,
    output bcd, count, full, accept, err, ovf
  );
endinterface

// File: rtl/dec_bcd_accumulator.sv
// Decimal entry register: validates one-hot key digits, encodes them to BCD and shifts them
// into a DIGITS-wide packed register, with backspace, clear, full, error and overflow reporting.
module dec_bcd_accumulator #(
  parameter int DIGITS = 4  // legal range 1..8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dec_bcd_accumulator_if.slave  bus
);
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DIGITS);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [CW-1:0]       count_q, count_d;
  logic                accept_q, accept_d;
  logic                err_q, err_d;
  logic                ovf_q, ovf_d;

  logic                key_ok;
  logic [3:0]          digit_enc;
  logic [4*DIGITS-1:0] bcd_shifted;
  logic                full;

  function automatic logic [3:0] enc(input logic [9:0] v);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < 10; k++) begin
      if (v[k]) r = r | 4'(k);
    end
    return r;
  endfunction

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign key_ok    = (bus.inn != 10'd0) && ((bus.inn & (bus.inn - 10'd1)) == 10'd0);
  assign digit_enc = enc(bus.inn);
  assign full      = (count_q == FULL_CNT);

  generate
    if (DIGITS == 1) begin : g_single
      assign bcd_shifted = digit_enc;
    end else begin : g_multi
      assign bcd_shifted = {bcd_q[4*DIGITS-5:0], digit_enc};
    end
  endgenerate

  always_comb begin
    bcd_d    = bcd_q;
    count_d  = count_q;
    accept_d = 1'b0;
    err_d    = 1'b0;
    ovf_d    = 1'b0;
    if (bus.clear) begin
      bcd_d   = '0;
      count_d = '0;
    end else if (bus.bksp) begin
      if (count_q != '0) begin
        bcd_d   = bcd_q >> 4;
        count_d = count_q - ONE_CNT;
      end
    end else if (bus.key_valid) begin
      // A malformed key is reported as an error even when the register is full.
      if (!key_ok) begin
        err_d = 1'b1;
      end else if (full) begin
        ovf_d = 1'b1;
      end else begin
        bcd_d    = bcd_shifted;
        count_d  = count_q + ONE_CNT;
        accept_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q    <= '0;
      count_q  <= '0;
      accept_q <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      bcd_q    <= bcd_d;
      count_q  <= count_d;
      accept_q <= accept_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.bcd    = bcd_q;
  assign bus.count  = count_q;
  assign bus.full   = full;
  assign bus.accept = accept_q;
  assign bus.err    = err_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_dec_bcd_accumulator.sv
// Bench for dec_bcd_accumulator: DIGITS=4 against a digit-queue model, plus DIGITS=1 and DIGITS=8 builds.
module tb_dec_bcd_accumulator;
  localparam int OBS_W = 16 + 3 + 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [OBS_W-1:0] exp_q[$];
  int               m4_q[$];

  dec_bcd_accumulator_if #(.DIGITS(4)) bus4 ();
  dec_bcd_accumulator_if #(.DIGITS(1)) bus1 ();
  dec_bcd_accumulator_if #(.DIGITS(8)) bus8 ();

  dec_bcd_accumulator #(.DIGITS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  dec_bcd_accumulator #(.DIGITS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  dec_bcd_accumulator #(.DIGITS(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic logic [OBS_W-1:0] model_obs(input logic a, input logic e, input logic o);
    logic [15:0] b;
    int          n;
    int          d;
    b = '0;
    n = m4_q.size();
    for (int i = 0; i < n; i++) begin
      d = m4_q[n-1-i];
      b[4*i +: 4] = 4'(d);
    end
    return {b, 3'(n), (n == 4), a, e, o};
  endfunction

  function automatic logic [OBS_W-1:0] obs4();
    return {bus4.bcd, bus4.count, bus4.full, bus4.accept, bus4.err, bus4.ovf};
  endfunction

  // ---------------- driver ----------------
  task automatic drive4(input logic c, input logic b, input logic k, input logic [9:0] in);
    logic a, e, o;
    int   d;
    a = 1'b0; e = 1'b0; o = 1'b0; d = 0;
    bus4.clear = c; bus4.bksp = b; bus4.key_valid = k; bus4.inn = in;
    if (c) begin
      m4_q.delete();
    end else if (b) begin
      if (m4_q.size() > 0) void'(m4_q.pop_back());
    end else if (k) begin
      if ($countones(in) != 1) e = 1'b1;
      else if (m4_q.size() == 4) o = 1'b1;
      else begin
        for (int i = 0; i < 10; i++) if (in[i]) d = i;
        m4_q.push_back(d);
        a = 1'b1;
      end
    end
    exp_q.push_back(model_obs(a, e, o));
    @(posedge clk);
    #1;
  endtask

  task automatic idle4();
    bus4.clear = 1'b0; bus4.bksp = 1'b0; bus4.key_valid = 1'b0; bus4.inn = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [OBS_W-1:0] got;
    rst_n = 1'b0;
    idle4();
    bus1.clear = 0; bus1.bksp = 0; bus1.key_valid = 0; bus1.inn = '0;
    bus8.clear = 0; bus8.bksp = 0; bus8.key_valid = 0; bus8.inn = '0;
    m4_q.delete();
    #12;
    got = obs4();
    n_vec++;
    if (got !== '0) begin
      n_err++;
      $display("FAIL reset_state: got %h expected %h", got, {OBS_W{1'b0}});
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_entry();
    logic [12:0] cmds [3] = '{{3'b001, 10'b0000000100}, {3'b001, 10'b0000001000},
                              {3'b001, 10'b1000000000}};
    logic [OBS_W-1:0] got, exp;
    foreach (cmds[i]) begin
      drive4(cmds[i][12], cmds[i][11], cmds[i][10], cmds[i][9:0]);
      got = obs4(); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL entry[%0d]: got %h expected %h", i, got, exp);
      end
    end
    n_vec++;
    if (bus4.bcd !== 16'h0239 || bus4.count !== 3'd3 || bus4.full !== 1'b0) begin
      n_err++;
      $display("FAIL entry_value: got bcd=%h count=%0d full=%b expected bcd=0239 count=3 full=0",
               bus4.bcd, bus4.count, bus4.full);
    end
  endtask

  task automatic test_invalid();
    logic [12:0] cmds [5] = '{{3'b100, 10'd0}, {3'b001, 10'b0000100000},
                              {3'b001, 10'b0001000000}, {3'b001, 10'b0000000000},
                              {3'b001, 10'b0100000100}};
    logic [OBS_W-1:0] got, exp;
    foreach (cmds[i]) begin
      drive4(cmds[i][12], cmds[i][11], cmds[i][10], cmds[i][9:0]);
      got = obs4(); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL invalid[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_full_ovf();
    logic [12:0] cmds [7] = '{{3'b100, 10'd0}, {3'b001, 10'b0000000010},
                              {3'b001, 10'b0000000100}, {3'b001, 10'b0000001000},
                              {3'b001, 10'b0000010000}, {3'b001, 10'b0000100000},
                              {3'b001, 10'b0000000011}};
    logic [OBS_W-1:0] got, exp;
    foreach (cmds[i]) begin
      drive4(cmds[i][12], cmds[i][11], cmds[i][10], cmds[i][9:0]);
      got = obs4(); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL full_ovf[%0d]: got %h expected %h", i, got, exp);
      end
    end
    n_vec++;
    if (bus4.bcd !== 16'h1234 || bus4.count !== 3'd4 || bus4.err !== 1'b1 || bus4.ovf !== 1'b0) begin
      n_err++;
      $display("FAIL full_value: got bcd=%h count=%0d err=%b ovf=%b expected 1234 4 1 0",
               bus4.bcd, bus4.count, bus4.err, bus4.ovf);
    end
  endtask

  task automatic test_bksp_priority();
    logic [12:0] cmds [4] = '{{3'b010, 10'd0}, {3'b011, 10'b0010000000},
                              {3'b110, 10'd0}, {3'b010, 10'd0}};
    logic [OBS_W-1:0] got, exp;
    foreach (cmds[i]) begin
      drive4(cmds[i][12], cmds[i][11], cmds[i][10], cmds[i][9:0]);
      got = obs4(); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL bksp[%0d]: got %h expected %h", i, got, exp);
      end
      if (i == 1) begin
        n_vec++;
        if (bus4.bcd !== 16'h0012 || bus4.accept !== 1'b0) begin
          n_err++;
          $display("FAIL bksp_over_key: got bcd=%h accept=%b expected 0012 0", bus4.bcd, bus4.accept);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [12:0] cmds [5] = '{{3'b100, 10'd0}, {3'b001, 10'b0000000001},
                              {3'b001, 10'b1000000000}, {3'b001, 10'b0100000000},
                              {3'b001, 10'b0010000000}};
    logic [OBS_W-1:0] got, exp;
    foreach (cmds[i]) begin
      drive4(cmds[i][12], cmds[i][11], cmds[i][10], cmds[i][9:0]);
      got = obs4(); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL pre_reset[%0d]: got %h expected %h", i, got, exp);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus4.bcd !== 16'h0 || bus4.count !== 3'd0) begin
      n_err++;
      $display("FAIL async_reset: got bcd=%h count=%0d expected 0 0", bus4.bcd, bus4.count);
    end
    #1;
    rst_n = 1'b1;
    m4_q.delete();
    drive4(1'b0, 1'b0, 1'b1, 10'b0000010000);
    drive4(1'b0, 1'b0, 1'b1, 10'b0000000010);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      exp = exp_q.pop_front();
      if (i == 1) begin
        got = obs4();
        if (got !== exp) begin
          n_err++;
          $display("FAIL post_reset: got %h expected %h", got, exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [OBS_W-1:0] got, exp;
    drive4(1'b1, 1'b0, 1'b0, '0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 6; i++) begin
      drive4(1'b0, 1'b0, 1'b1, 10'(1) << $urandom_range(0, 9));
      got = obs4(); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [OBS_W-1:0] got, exp;
    logic [9:0]       in;
    int               r;
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 99);
      in = ($urandom_range(0, 9) < 7) ? (10'(1) << $urandom_range(0, 9)) : 10'($urandom_range(0, 1023));
      drive4(r < 5, (r >= 5 && r < 25) || (r < 3), r >= 15 || ($urandom_range(0, 3) == 0), in);
      got = obs4(); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL random[%0d]: got %h expected %h", i, got, exp);
      end
    end
    idle4();
  endtask

  task automatic test_digits1();
    bus1.key_valid = 1'b1; bus1.inn = 10'(1) << 6;
    @(posedge clk); #1;
    n_vec++;
    if (bus1.bcd !== 4'h6 || bus1.full !== 1'b1 || bus1.accept !== 1'b1 || bus1.count !== 1'b1) begin
      n_err++;
      $display("FAIL d1_enter: got bcd=%h full=%b accept=%b expected 6 1 1", bus1.bcd, bus1.full, bus1.accept);
    end
    bus1.inn = 10'(1) << 3;
    @(posedge clk); #1;
    n_vec++;
    if (bus1.bcd !== 4'h6 || bus1.ovf !== 1'b1 || bus1.accept !== 1'b0) begin
      n_err++;
      $display("FAIL d1_ovf: got bcd=%h ovf=%b accept=%b expected 6 1 0", bus1.bcd, bus1.ovf, bus1.accept);
    end
    bus1.key_valid = 1'b0; bus1.bksp = 1'b1;
    @(posedge clk); #1;
    bus1.bksp = 1'b0; bus1.key_valid = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (bus1.bcd !== 4'h3 || bus1.full !== 1'b1) begin
      n_err++;
      $display("FAIL d1_reenter: got bcd=%h full=%b expected 3 1", bus1.bcd, bus1.full);
    end
    bus1.key_valid = 1'b0;
  endtask

  task automatic test_digits8();
    for (int i = 1; i <= 8; i++) begin
      bus8.key_valid = 1'b1; bus8.inn = 10'(1) << i;
      @(posedge clk); #1;
      n_vec++;
      if (bus8.accept !== 1'b1 || bus8.count !== 4'(i)) begin
        n_err++;
        $display("FAIL d8_accept[%0d]: got accept=%b count=%0d expected 1 %0d", i, bus8.accept, bus8.count, i);
      end
    end
    n_vec++;
    if (bus8.bcd !== 32'h12345678 || bus8.full !== 1'b1) begin
      n_err++;
      $display("FAIL d8_value: got bcd=%h full=%b expected 12345678 1", bus8.bcd, bus8.full);
    end
    bus8.inn = 10'(1) << 9;
    @(posedge clk); #1;
    n_vec++;
    if (bus8.ovf !== 1'b1 || bus8.bcd !== 32'h12345678) begin
      n_err++;
      $display("FAIL d8_ovf: got ovf=%b bcd=%h expected 1 12345678", bus8.ovf, bus8.bcd);
    end
    bus8.key_valid = 1'b0;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_entry();
    test_invalid();
    test_full_ovf();
    test_bksp_priority();
    test_async_reset();
    test_back_to_back();
    test_random();
    test_digits1();
    test_digits8();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dec_bcd_accumulator.md
# dec_bcd_accumulator

Multi-digit decimal entry register built on the one-hot decimal-to-BCD encoder. Each accepted key strobe carries a one-hot 10-bit digit. The block validates it, encodes it to BCD and shifts it into a DIGITS-wide packed BCD register, with backspace, clear, full and error handling. It sits between a keypad or one-hot digit source and downstream BCD display or arithmetic logic. All outputs are registered.

## Interface
- DIGITS, 4: number of BCD digits held; legal range 1..8.
- CW, $clog2(DIGITS+1): width of the digit count; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inn  in  10  one-hot decimal digit; bit k set means digit k.
- key_valid  in  1  strobe: inn is presented this cycle.
- bksp  in  1  strobe: remove the most recently entered digit.
- clear  in  1  strobe: empty the register.
- bcd  out  4*DIGITS  packed BCD value.
  - bcd[3:0] is the most recent digit (least significant).
  - Unused upper digits read 0.
- count  out  CW  number of digits held, 0..DIGITS.
- full  out  1  high when count == DIGITS.
- accept  out  1  one-cycle pulse: a digit was shifted in.
- err  out  1  one-cycle pulse: key_valid with an invalid inn (zero or more than one bit set).
- ovf  out  1  one-cycle pulse: key_valid with a valid inn while full.

## Operation
Reset (rst_n low, asynchronous): bcd=0, count=0, full=0, accept=0, err=0, ovf=0.

Per-cycle commands are resolved by priority: clear > bksp > key_valid. Exactly one action is taken per cycle; lower-priority strobes in the same cycle are dropped and raise no flags.

- clear: bcd=0, count=0. No pulses.
- bksp with count>0:
  - bcd shifts right by 4, with 0 filling the top nibble.
  - count decrements by 1.
- bksp with count==0: no change, no pulse.
- key_valid with valid one-hot inn and count<DIGITS:
  - bcd = {bcd[4*DIGITS-5:0], enc(inn)}.
  - count increments by 1.
  - accept=1.
- key_valid with valid inn and count==DIGITS: bcd and count unchanged, ovf=1 (the new digit is rejected).
- key_valid with invalid inn: bcd and count unchanged, err=1. This check takes precedence over the full check, so ovf stays 0.
- enc(inn) maps bit k to 4'dk for k=0..9. Outputs never take X values.
- With DIGITS==1, the shift degenerates to a replace of the only digit, gated by full.

full is combinational from registered count, equal to (count==DIGITS). Because it derives only from registered state, it is glitch-free.

## Timing
- Latency is one clock: a strobe sampled at edge N is reflected on bcd, count and the pulses after edge N.
- accept, err and ovf are high for exactly one cycle per qualifying strobe.
- Strobes held high for multiple cycles act once per cycle. There is no edge detection.
- Back-to-back key_valid cycles each accept a digit until full.
- Reset asserted mid-operation clears all state immediately, without waiting for clk.
- The first edge after rst_n deasserts processes inputs normally.
- Inputs are sampled only at the rising clk edge. inn is a don't-care when key_valid=0.

## Test plan
- Reset, then key_valid with inn=0000000100, 0000001000, 1000000000 on consecutive cycles (DIGITS=4):
  - bcd=16'h0239, count=3, full=0.
  - accept pulses on 3 consecutive cycles.
- Invalid inputs with count=2:
  - inn=0000000000 -> err=1, bcd unchanged.
  - inn=0100000100 -> err=1, bcd unchanged.
  - ovf=0 and accept=0 throughout.
- Fill with 1,2,3,4:
  - bcd=16'h1234, full=1.
  - Then digit 5 -> ovf=1, bcd=16'h1234, count=4.
  - Then an invalid key while full -> err=1, ovf=0.
- From bcd=16'h1234:
  - bksp -> bcd=16'h0123, count=3.
  - Same-cycle bksp+key_valid(digit 7) -> bcd=16'h0012, count=2, accept=0.
  - clear+bksp -> bcd=0, count=0.
  - bksp at count 0 -> no change.
- Asynchronous reset pulse between clock edges while bcd=16'h0987:
  - bcd=0 and count=0 immediately, before the next edge.
  - Entry resumes correctly afterward.
- DIGITS=1 and DIGITS=8 builds:
  - 1: digit 6 -> bcd=4'h6, full=1; digit 3 -> ovf=1.
  - 8: entering 1..8 -> bcd=32'h12345678, full=1.
